if_stage: RTL and testbench



---
 rtl/cpu_pkg.sv | 18 +
 rtl/if_queue.sv | 58 +++++
 rtl/if_stage.sv | 89 ++++++++
 tb/tb_if_stage.sv | 139 +++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and the fetch-queue entry type.
// word_align is used wherever a byte address becomes a fetch address.
package cpu_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] RESET_PC = 32'h1c00_0000;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_queue.sv
// Circular FIFO of fetched {pc, inst} pairs between the inst SRAM and decode.
// Flush empties it in one cycle; head outputs are read straight from storage.
module if_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic [INST_W-1:0] push_inst,
  input  logic              pop,
  output logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] head_pc,
  output logic [INST_W-1:0] head_inst
);

  fetch_entry_t     mem_reg [DEPTH];
  logic [PTR_W-1:0] head_reg, tail_reg;
  logic [CNT_W-1:0] count_reg;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push && !flush && !reset)
      mem_reg[tail_reg] <= '{pc: push_pc, inst: push_inst};
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) tail_reg <= ptr_inc(tail_reg);
      if (pop)  head_reg <= ptr_inc(head_reg);
      if (push && !pop)
        count_reg <= count_reg + 1'b1;
      else if (pop && !push)
        count_reg <= count_reg - 1'b1;
    end
  end

  // The issue rule upstream keeps count+inflight <= DEPTH, so this never fires.
  assert property (@(posedge clk) disable iff (reset || flush)
                   !(push && count_reg == CNT_W'(DEPTH)));

  assign count     = count_reg;
  assign head_pc   = mem_reg[head_reg].pc;
  assign head_inst = mem_reg[head_reg].inst;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the fetch PC, drives the synchronous inst SRAM and
// hands {pc, inst} to decode; a redirect discards every wrong-path fetch.
module if_stage #(
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        inst_sram_en,
  output logic        inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
);
  import cpu_pkg::*;

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
  logic [ADDR_W-1:0] req_pc_reg, req_pc_next;
  logic              inflight_reg, inflight_next;
  logic [CNT_W-1:0]  q_count;
  logic [ADDR_W-1:0] head_pc;
  logic [INST_W-1:0] head_inst;
  logic              pop, push, issue;
  logic [CNT_W:0]    occupancy, issue_limit;

  assign out_valid = (q_count != '0) & ~br_valid & ~reset;
  assign pop       = out_valid & out_ready;
  assign push      = inflight_reg & ~br_valid;

  // Comparing against DEPTH+pop avoids underflow of count+inflight-pop; the
  // out_ready dependency is what sustains one instruction per cycle.
  assign occupancy   = {1'b0, q_count} + (CNT_W + 1)'(inflight_reg);
  assign issue_limit = (CNT_W + 1)'(DEPTH) + (CNT_W + 1)'(pop);
  assign issue       = ~reset & ~br_valid & (occupancy < issue_limit);

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    req_pc_next   = req_pc_reg;
    inflight_next = issue;
    if (br_valid) begin
      fetch_pc_next = word_align(br_target);
      inflight_next = 1'b0;
    end else if (issue) begin
      fetch_pc_next = fetch_pc_reg + 32'd4;
      req_pc_next   = word_align(fetch_pc_reg);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_reg <= RESET_PC;
      req_pc_reg   <= '0;
      inflight_reg <= 1'b0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      req_pc_reg   <= req_pc_next;
      inflight_reg <= inflight_next;
    end
  end

  if_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (br_valid),
    .push      (push),
    .push_pc   (req_pc_reg),
    .push_inst (inst_sram_rdata),
    .pop       (pop),
    .count     (q_count),
    .head_pc   (head_pc),
    .head_inst (head_inst)
  );

  assign inst_sram_en    = issue;
  assign inst_sram_we    = 1'b0;
  assign inst_sram_addr  = word_align(fetch_pc_reg);
  assign inst_sram_wdata = '0;
  assign out_pc          = out_valid ? head_pc : '0;
  assign out_inst        = out_valid ? head_inst : '0;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios then random traffic, checked against
// a transaction model (queue of fetched PCs tagged with the cycle they become visible).
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h1c00_0000;
  localparam logic [31:0] KEY    = 32'hA5A5_0000;
  localparam int          DEPTH  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_sram_en, inst_sram_we;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic [31:0] inst_sram_rdata = '0;
  logic        br_valid = 1'b0;
  logic [31:0] br_target = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc, out_inst;

  if_stage #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata),
    .br_valid        (br_valid),
    .br_target       (br_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_inst        (out_inst)
  );

  always #5 clk = ~clk;

  // Synchronous SRAM: data for the address presented in the previous cycle.
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= inst_sram_addr ^ KEY;
  end

  typedef struct {
    logic [31:0] pc;
    int          avail;
  } fetch_t;

  fetch_t      fq[$];
  logic [31:0] next_pc = RST_PC;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input logic rst, input logic br, input logic [31:0] tgt, input logic rdy);
    logic exp_valid, exp_pop, exp_en;
    @(posedge clk);
    #1;
    reset     = rst;
    br_valid  = br;
    br_target = tgt;
    out_ready = rdy;
    @(negedge clk);
    exp_valid = !rst && !br && fq.size() > 0 && fq[0].avail <= cyc;
    exp_pop   = exp_valid && rdy;
    exp_en    = !rst && !br && (fq.size() - (exp_pop ? 1 : 0) < DEPTH);
    check("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
    if (exp_valid) begin
      check("out_pc", out_pc, fq[0].pc);
      check("out_inst", out_inst, fq[0].pc ^ KEY);
    end
    check("sram_en", {31'b0, inst_sram_en}, {31'b0, exp_en});
    if (exp_en) check("sram_addr", inst_sram_addr, next_pc);
    if (rst) begin
      check("rst_out_pc", out_pc, 32'h0);
      check("rst_sram_we_wdata", inst_sram_wdata | {31'b0, inst_sram_we}, 32'h0);
    end
    $display("cyc %0d rst=%0b br=%0b rdy=%0b en=%0b addr=%h valid=%0b pc=%h inst=%h",
             cyc, rst, br, rdy, inst_sram_en, inst_sram_addr, out_valid, out_pc, out_inst);
    if (rst) begin
      fq.delete();
      next_pc = RST_PC;
    end else if (br) begin
      fq.delete();
      next_pc = {tgt[31:2], 2'b00};
    end else begin
      if (exp_pop) void'(fq.pop_front());
      if (exp_en) begin
        fq.push_back('{pc: next_pc, avail: cyc + 2});
        next_pc = next_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  initial begin
    logic [31:0] tgt;
    repeat (2) step(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1);
    // Back-pressure then drain.
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b0);
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);
    // Redirect with the queue occupied.
    repeat (2) step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h1c00_0100, 1'b1);
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);
    // Misaligned target.
    step(1'b0, 1'b1, 32'h1c00_0102, 1'b1);
    repeat (5) step(1'b0, 1'b0, 32'h0, 1'b1);
    // Back-to-back redirects.
    step(1'b0, 1'b1, 32'h1c00_0200, 1'b1);
    step(1'b0, 1'b1, 32'h1c00_0300, 1'b1);
    repeat (5) step(1'b0, 1'b0, 32'h0, 1'b1);
    // Reset mid-stream with the queue full.
    repeat (4) step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    repeat (5) step(1'b0, 1'b0, 32'h0, 1'b1);
    // Fetch PC wrap-around.
    step(1'b0, 1'b1, 32'hffff_fff8, 1'b1);
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      tgt = $urandom;
      if ($urandom_range(0, 3) == 0) tgt = 32'hffff_fff0 | (tgt & 32'hf);
      step($urandom_range(0, 63) == 0, $urandom_range(0, 9) == 0, tgt,
           $urandom_range(0, 3) != 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
